// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, LSB first, one full-adder cell per clock.
// The full-adder cell is two halfadder instances plus an OR for the carry.

module halfadder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             p, g0, s, g1, c_next;

    halfadder u_ha0 (.x(a_q[0]), .y(b_q[0]), .s(p), .c(g0));
    halfadder u_ha1 (.x(p), .y(carry_q), .s(s), .c(g1));
    assign c_next = g0 | g1;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && start) begin
            state_d = ADD;
            a_d     = a;
            b_d     = b;
            carry_d = 1'b0;
            cnt_d   = '0;
        end else if (state_q == ADD) begin
            sum_d   = {s, sum_q[WIDTH-1:1]};
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = c_next;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d = DONE;
                cout_d  = c_next;
            end
        end else begin
            // DONE and the unused encoding both fall back to IDLE
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == ADD);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=4 and WIDTH=8,
// reference results are plain a+b with the carry as bit WIDTH.

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start4 = 1'b0, start8 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       busy4, done4, cout4, busy8, done8, cout8;
    logic       prev4 = 1'b0, prev8 = 1'b0;
    int         pass_cnt = 0, total_cnt = 0;
    logic [8:0] q4[$], q8[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );
    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    task automatic chk(input string n, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", n, act, exp);
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done4) begin
            chk("done4_single_cycle", int'(prev4), 0);
            if (q4.size() == 0) begin
                total_cnt++;
                $display("FAIL spurious_done4: got sum=%0d cout=%0d with no pending add", sum4, cout4);
            end else chk("result4", int'({cout4, sum4}), int'(q4.pop_front()));
        end
        if (done8) begin
            chk("done8_single_cycle", int'(prev8), 0);
            if (q8.size() == 0) begin
                total_cnt++;
                $display("FAIL spurious_done8: got sum=%0d cout=%0d with no pending add", sum8, cout8);
            end else chk("result8", int'({cout8, sum8}), int'(q8.pop_front()));
        end
        prev4 <= done4;
        prev8 <= done8;
    end

    task automatic do_add(input bit w8, input logic [7:0] x, input logic [7:0] y, input bit poke);
        int w = w8 ? 8 : 4;
        int cyc = 0, bcnt = 0;
        int exp_v = w8 ? int'(x) + int'(y) : int'(x[3:0]) + int'(y[3:0]);
        @(posedge clk); #1;
        if (w8) begin a8 = x; b8 = y; start8 = 1'b1; q8.push_back(9'(exp_v)); end
        else begin a4 = x[3:0]; b4 = y[3:0]; start4 = 1'b1; q4.push_back(9'(exp_v)); end
        @(posedge clk); #1;
        start4 = 1'b0; start8 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        while (!(w8 ? done8 : done4) && cyc < 3 * w) begin
            if (w8 ? busy8 : busy4) bcnt++;
            if (poke) begin start4 = (cyc == 1); a4 = 4'd1; b4 = 4'd1; end
            @(posedge clk); #1;
            cyc++;
        end
        start4 = 1'b0;
        chk("latency", cyc, w);
        chk("busy_cycles", bcnt, w);
        @(posedge clk); #1;
        chk("done_cleared", int'(w8 ? done8 : done4), 0);
        chk("idle_hold", w8 ? int'({cout8, sum8}) : int'({cout4, sum4}), exp_v);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish before 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        int nd, last;
        #2;
        chk("rst_busy4", int'(busy4), 0);
        chk("rst_done4", int'(done4), 0);
        chk("rst_sum4", int'({cout4, sum4}), 0);
        chk("rst_sum8", int'({cout8, sum8, busy8, done8}), 0);
        #21 rst_n = 1'b1;

        do_add(1'b0, 8'd5, 8'd3, 1'b0);
        do_add(1'b0, 8'd15, 8'd1, 1'b0);
        do_add(1'b0, 8'd15, 8'd15, 1'b0);
        do_add(1'b0, 8'd0, 8'd0, 1'b0);
        do_add(1'b0, 8'd6, 8'd7, 1'b1);

        // abort after two ADD edges: everything clears with no done pulse
        @(posedge clk); #1;
        a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy4), 0);
        chk("abort_done", int'(done4), 0);
        chk("abort_sum", int'({cout4, sum4}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_add(1'b0, 8'd2, 8'd3, 1'b0);

        // start held high: back-to-back adds every WIDTH+2 cycles
        @(posedge clk); #1;
        a4 = 4'd1; b4 = 4'd2; start4 = 1'b1;
        repeat (3) q4.push_back(9'd3);
        nd = 0; last = 0;
        for (int c = 0; c < 40 && nd < 3; c++) begin
            @(posedge clk); #1;
            if (done4) begin
                if (nd > 0) chk("held_spacing", c - last, 6);
                last = c;
                nd++;
                if (nd == 3) start4 = 1'b0;
            end else if (!busy4 && nd > 0) chk("held_idle_sum", int'({cout4, sum4}), 3);
        end
        chk("held_dones", nd, 3);
        @(posedge clk); #1;

        do_add(1'b1, 8'd200, 8'd100, 1'b0);
        do_add(1'b1, 8'd255, 8'd255, 1'b0);
        for (int i = 0; i < 30; i++) do_add(1'b1, 8'($urandom), 8'($urandom), 1'b0);
        for (int i = 0; i < 256; i++) do_add(1'b0, 8'(i >> 4), 8'(i & 15), 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("q4_drained", q4.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
